// File: rtl/alu_shift_pkg.sv
// Shared types and default widths for the iterative shift unit.
package alu_shift_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_RSVD = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/alu_shift_stage.sv
// One conditional shift by 2**i_idx; combinational, zero latency, no flow control.
// The SRA fill comes from i_fill so the caller can supply the original sign.
module alu_shift_stage
   import alu_shift_pkg::*;
#(
   parameter int DATA_W  = alu_shift_pkg::DATA_W,
   parameter int SHAMT_W = alu_shift_pkg::SHAMT_W,
   parameter int IDX_W   = 3
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic              i_en,
   input  logic [1:0]        i_op,
   input  logic              i_fill,
   output logic [DATA_W-1:0] o_data
);

   logic [SHAMT_W-1:0] w_amt;
   logic [DATA_W-1:0]  w_ones;
   logic [DATA_W-1:0]  w_fill_mask;

   assign w_amt       = SHAMT_W'(1) << i_idx;
   assign w_ones      = '1;
   assign w_fill_mask = i_fill ? ~(w_ones >> w_amt) : '0;

   always_comb begin
      o_data = i_data;
      if (i_en) begin
         case (shift_op_e'(i_op))
            OP_SLL:  o_data = i_data << w_amt;
            OP_SRL:  o_data = i_data >> w_amt;
            OP_SRA:  o_data = (i_data >> w_amt) | w_fill_mask;
            default: o_data = i_data;
         endcase
      end
   end

endmodule

// File: rtl/alu_shift_multicycle.sv
// Iterative SLL/SRL/SRA, one shamt bit per cycle: SHAMT_W cycles, or 1 + top set bit with ALU_SHIFT_EARLY_EXIT_EN.
// Accepts only in IDLE; the result is held in DONE until i_ready, with no overlap with the next accept.
module alu_shift_multicycle
   import alu_shift_pkg::*;
#(
   parameter int DATA_W  = alu_shift_pkg::DATA_W,
   parameter int SHAMT_W = alu_shift_pkg::SHAMT_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_result,
   output logic              o_busy
);

   localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

   state_e             r_state;
   state_e             w_next;
   logic [DATA_W-1:0]  r_acc;
   logic [SHAMT_W-1:0] r_shamt;
   logic [IDX_W-1:0]   r_idx;
   logic [1:0]         r_op;
   logic               r_sign;

   logic               w_accept;
   logic               w_last;
   logic               w_step_en;
   logic [DATA_W-1:0]  w_stage;
   logic               w_unused_b;

   assign w_unused_b = ^i_b[DATA_W-1:SHAMT_W];
   assign w_accept   = i_valid && (r_state == ST_IDLE);
   assign w_step_en  = r_shamt[r_idx] && (r_op != OP_RSVD);

`ifdef ALU_SHIFT_EARLY_EXIT_EN
   // Stop as soon as no higher shamt bits remain to be processed.
   assign w_last = (r_idx == IDX_W'(SHAMT_W - 1)) ||
                   ((r_shamt >> (r_idx + IDX_W'(1))) == '0);
`else
   assign w_last = (r_idx == IDX_W'(SHAMT_W - 1));
`endif

   alu_shift_stage #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W),
      .IDX_W   (IDX_W)
   ) u_stage (
      .i_data (r_acc),
      .i_idx  (r_idx),
      .i_en   (w_step_en),
      .i_op   (r_op),
      .i_fill (r_sign),
      .o_data (w_stage)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_valid) w_next = ST_SHIFT;
         ST_SHIFT: if (w_last)  w_next = ST_DONE;
         ST_DONE:  if (i_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Sign is captured from the original operand since acc is rewritten every step.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc   <= '0;
         r_shamt <= '0;
         r_idx   <= '0;
         r_op    <= '0;
         r_sign  <= 1'b0;
      end else if (w_accept) begin
         r_acc   <= i_a;
         r_shamt <= i_b[SHAMT_W-1:0];
         r_idx   <= '0;
         r_op    <= i_op;
         r_sign  <= i_a[DATA_W-1];
      end else if (r_state == ST_SHIFT) begin
         r_acc <= w_stage;
         r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
   end

   assign o_ready  = (r_state == ST_IDLE);
   assign o_valid  = (r_state == ST_DONE);
   assign o_busy   = (r_state == ST_SHIFT) || (r_state == ST_DONE);
   assign o_result = (r_state == ST_DONE) ? r_acc : '0;

endmodule

// File: tb/tb_alu_shift_multicycle.sv
// Directed bench for alu_shift_multicycle; latency expectations follow ALU_SHIFT_EARLY_EXIT_EN.
module tb_alu_shift_multicycle;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_op;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   alu_shift_multicycle dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_busy   (o_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [4:0] sh);
      int l;
      l = 5;
`ifdef ALU_SHIFT_EARLY_EXIT_EN
      l = 1;
      for (int k = 0; k < 5; k++) if (sh[k]) l = k + 1;
`endif
      return l;
   endfunction

   // Issue one op, count edges until o_valid, optionally stall writeback, then drain.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
      int lat;
      check({tag, "_ready_idle"}, 32'(o_ready), 32'd1);
      i_valid = 1'b1;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      i_ready = (hold == 0);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_a     = ~a;
      i_b     = ~b;
      i_op    = ~op;
      check({tag, "_busy"}, 32'(o_busy), 32'd1);
      check({tag, "_ready_shift"}, 32'(o_ready), 32'd0);
      lat = 0;
      while (o_valid !== 1'b1 && lat < 40) begin
         @(posedge i_clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat(b[4:0])));
      check({tag, "_result"}, o_result, exp);
      check({tag, "_ready_done"}, 32'(o_ready), 32'd0);
      for (int k = 0; k < hold; k++) begin
         @(posedge i_clk); #1;
         check({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
         check({tag, "_hold_result"}, o_result, exp);
         check({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      check({tag, "_valid_gone"}, 32'(o_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
      check({tag, "_busy_gone"}, 32'(o_busy), 32'd0);
      i_ready = 1'b0;
   endtask

   initial begin
      int seen;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_op    = 2'b00;
      i_a     = '0;
      i_b     = '0;
      @(posedge i_clk); @(posedge i_clk); #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_result", o_result, 32'd0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      check("rst_ready", 32'(o_ready), 32'd1);

      run_op("sra_neg4",  2'b10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0);
      run_op("sll_63",    2'b00, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 0);
      run_op("srl_28",    2'b01, 32'hF000_0000, 32'h0000_001C, 32'h0000_000F, 0);
      run_op("sra_pos31", 2'b10, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 0);
      run_op("rsvd",      2'b11, 32'h1234_5678, 32'h0000_001F, 32'h1234_5678, 0);
      run_op("sra_sh0",   2'b10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0);
      run_op("sll_3",     2'b00, 32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 0);
      run_op("srl_16",    2'b01, 32'h8000_0000, 32'h0000_0010, 32'h0000_8000, 0);
      run_op("sra_1",     2'b10, 32'hF000_0000, 32'hFFFF_FFE1, 32'hF800_0000, 0);
      run_op("bp_sra",    2'b10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 10);

      // Reset two cycles into a shift must abandon the operation.
      i_valid = 1'b1;
      i_op    = 2'b00;
      i_a     = 32'h0000_0001;
      i_b     = 32'h0000_001F;
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      check("mid_busy", 32'(o_busy), 32'd1);
      i_rst = 1'b1;
      #1;
      check("arst_valid", 32'(o_valid), 32'd0);
      check("arst_busy", 32'(o_busy), 32'd0);
      check("arst_ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clk); #1;
         if (o_valid === 1'b1) seen++;
      end
      check("arst_no_result", 32'(seen), 32'd0);
      i_ready = 1'b0;

      run_op("post_rst", 2'b01, 32'hF000_0000, 32'h0000_001C, 32'h0000_000F, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
